// File: rtl/input_vc_buffer.sv
// input_vc_buffer: per-VC circular FIFOs for one router input port.
// All per-VC vectors (grant_in, is_new_flit, credit_out, full_out,
// overflow_err and the slices of flit_out) carry VC 0 in the most
// significant position.
// Optional: define INBUF_OVERFLOW_CHECK_EN to add the sticky overflow_err
// output flagging pushes dropped on a full VC.
`ifndef FLIT_SIZE
`define FLIT_SIZE 32
`endif

module input_vc_buffer #(
  parameter int VC_NUM  = 4,
  parameter int DEPTH   = 4,
  parameter int VC_ID_W = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flit_valid_in,
  input  logic [VC_ID_W-1:0]           flit_vc_in,
  input  logic [`FLIT_SIZE-1:0]        flit_in,
  input  logic [VC_NUM-1:0]            grant_in,
  output logic [`FLIT_SIZE*VC_NUM-1:0] flit_out,
  output logic [VC_NUM-1:0]            is_new_flit,
  output logic [VC_NUM-1:0]            credit_out,
  output logic [VC_NUM-1:0]            full_out
`ifdef INBUF_OVERFLOW_CHECK_EN
  ,
  output logic [VC_NUM-1:0]            overflow_err
`endif
);

  localparam int FS    = `FLIT_SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr [VC_NUM];
  logic [PTR_W-1:0] wr_ptr [VC_NUM];
  logic [CNT_W-1:0] count  [VC_NUM];
  logic [FS-1:0]    mem    [VC_NUM][DEPTH];

  // Indexed by VC number (not by vector bit position).
  logic [VC_NUM-1:0] nonempty;
  logic [VC_NUM-1:0] is_full;
  logic [VC_NUM-1:0] push_req;
  logic [VC_NUM-1:0] push_ok;
  logic [VC_NUM-1:0] pop_ok;

  // Per-VC status and push/pop qualification from registered occupancy.
  // Out-of-range VC ids never match a VC, so those flits are discarded.
  always_comb begin
    nonempty = '0;
    is_full  = '0;
    push_req = '0;
    push_ok  = '0;
    pop_ok   = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      nonempty[v] = (count[v] != '0);
      is_full[v]  = (count[v] == CNT_W'(DEPTH));
      push_req[v] = flit_valid_in && (32'(flit_vc_in) == v);
      pop_ok[v]   = grant_in[VC_NUM-1-v] && nonempty[v];
      // A pop in the same cycle frees the slot, so a full VC still accepts.
      push_ok[v]  = push_req[v] && (!is_full[v] || pop_ok[v]);
    end
  end

  // Map per-VC status onto the VC-0-most-significant output vectors.
  always_comb begin
    is_new_flit = '0;
    full_out    = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      is_new_flit[VC_NUM-1-v] = nonempty[v];
      full_out[VC_NUM-1-v]    = is_full[v];
    end
  end

  // Head flit of each VC; empty VCs show zero so stale storage stays hidden.
  always_comb begin
    flit_out = '0;
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (nonempty[v]) begin
        flit_out[(VC_NUM-1-v)*FS +: FS] = mem[v][rd_ptr[v]];
      end
    end
  end

  // Pointers, occupancy and credit pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
      end
      credit_out <= '0;
    end else begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (push_ok[v]) begin
          wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        end
        if (pop_ok[v]) begin
          rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        end
        if (push_ok[v] && !pop_ok[v]) begin
          count[v] <= count[v] + CNT_W'(1);
        end else if (!push_ok[v] && pop_ok[v]) begin
          count[v] <= count[v] - CNT_W'(1);
        end
        credit_out[VC_NUM-1-v] <= pop_ok[v];
      end
    end
  end

  // Flit storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < VC_NUM; v++) begin
      if (push_ok[v]) begin
        mem[v][wr_ptr[v]] <= flit_in;
      end
    end
  end

`ifdef INBUF_OVERFLOW_CHECK_EN
  // Sticky flag per VC for pushes dropped on a full VC.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err <= '0;
    end else begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (push_req[v] && is_full[v] && !pop_ok[v]) begin
          overflow_err[VC_NUM-1-v] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
// tb_input_vc_buffer: directed bench for input_vc_buffer with a scoreboard
// of expected pops (head data) and credit pulses checked by a monitor.
`ifndef FLIT_SIZE
`define FLIT_SIZE 32
`endif

module tb_input_vc_buffer;

  localparam int VC_NUM  = 4;
  localparam int DEPTH   = 4;
  localparam int VC_ID_W = 2;
  localparam int FS      = `FLIT_SIZE;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   flit_valid_in;
  logic [VC_ID_W-1:0]     flit_vc_in;
  logic [FS-1:0]          flit_in;
  logic [VC_NUM-1:0]      grant_in;
  logic [FS*VC_NUM-1:0]   flit_out;
  logic [VC_NUM-1:0]      is_new_flit;
  logic [VC_NUM-1:0]      credit_out;
  logic [VC_NUM-1:0]      full_out;
`ifdef INBUF_OVERFLOW_CHECK_EN
  logic [VC_NUM-1:0]      overflow_err;
`endif

  input_vc_buffer #(.VC_NUM(VC_NUM), .DEPTH(DEPTH), .VC_ID_W(VC_ID_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .flit_valid_in (flit_valid_in),
    .flit_vc_in    (flit_vc_in),
    .flit_in       (flit_in),
    .grant_in      (grant_in),
    .flit_out      (flit_out),
    .is_new_flit   (is_new_flit),
    .credit_out    (credit_out),
    .full_out      (full_out)
`ifdef INBUF_OVERFLOW_CHECK_EN
    ,
    .overflow_err  (overflow_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct { int vc; int cyc; logic [FS-1:0] data; } exp_t;
  exp_t pop_q[$];
  exp_t cred_q[$];

  function automatic logic [FS-1:0] head(input int v);
    return flit_out[(VC_NUM-1-v)*FS +: FS];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Announce a pop that the next clock edge must perform on VC vc with head d.
  task automatic expect_pop(input int vc, input logic [FS-1:0] d);
    exp_t e;
    e.vc = vc; e.cyc = cyc + 1; e.data = d;
    pop_q.push_back(e);
    cred_q.push_back(e);
  endtask

  // Apply one cycle of stimulus, advance past the edge, then idle the inputs.
  task automatic step(input logic fv, input int vc, input logic [FS-1:0] d,
                      input logic [VC_NUM-1:0] g);
    flit_valid_in = fv;
    flit_vc_in    = VC_ID_W'(vc);
    flit_in       = d;
    grant_in      = g;
    @(posedge clk); #1;
    flit_valid_in = 1'b0;
    flit_in       = '0;
    grant_in      = '0;
  endtask

  // Monitor: compare DUT pops and credit pulses against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (grant_in[VC_NUM-1-v] && is_new_flit[VC_NUM-1-v]) begin
          n_tests++;
          if (pop_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: vc %0d data %0h, none expected", v, head(v));
          end else begin
            exp_t e;
            e = pop_q.pop_front();
            if (e.vc != v || head(v) !== e.data) begin
              n_fail++;
              $display("FAIL pop_data: vc %0d data %0h, expected vc %0d data %0h",
                       v, head(v), e.vc, e.data);
            end
          end
        end
        if (credit_out[VC_NUM-1-v]) begin
          n_tests++;
          if (cred_q.size() == 0) begin
            n_fail++;
            $display("FAIL credit_unexpected: vc %0d at cycle %0d, none expected", v, cyc);
          end else begin
            exp_t e;
            e = cred_q.pop_front();
            if (e.vc != v || e.cyc != cyc) begin
              n_fail++;
              $display("FAIL credit: vc %0d cycle %0d, expected vc %0d cycle %0d",
                       v, cyc, e.vc, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flit_valid_in = 1'b0; flit_vc_in = '0; flit_in = '0; grant_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_is_new_flit", 256'(is_new_flit), 256'(4'b0000));
    check("rst_full_out", 256'(full_out), 256'(4'b0000));
    check("rst_credit_out", 256'(credit_out), 256'(4'b0000));
    check("rst_flit_out", 256'(flit_out), 256'(0));
`ifdef INBUF_OVERFLOW_CHECK_EN
    check("rst_overflow_err", 256'(overflow_err), 256'(4'b0000));
`endif

    // VC 1: A, B, C then three pops
    step(1'b1, 1, 32'hA, '0);
    check("vc1_visible_latency1", 256'(is_new_flit), 256'(4'b0100));
    check("vc1_head_A", 256'(head(1)), 256'(32'hA));
    step(1'b1, 1, 32'hB, '0);
    step(1'b1, 1, 32'hC, '0);
    expect_pop(1, 32'hA); step(1'b0, 0, '0, 4'b0100);
    expect_pop(1, 32'hB); step(1'b0, 0, '0, 4'b0100);
    expect_pop(1, 32'hC); step(1'b0, 0, '0, 4'b0100);
    check("vc1_empty_after_pops", 256'(is_new_flit), 256'(4'b0000));
    check("vc1_flit_out_zero", 256'(head(1)), 256'(0));
    step(1'b0, 0, '0, '0);

    // VC 0: fill, then a dropped fifth push
    for (int i = 0; i < 4; i++) step(1'b1, 0, 32'hD0 + 32'(i), '0);
    check("vc0_full", 256'(full_out), 256'(4'b1000));
    step(1'b1, 0, 32'hD4, '0);
    check("vc0_full_after_drop", 256'(full_out), 256'(4'b1000));
    check("vc0_head_after_drop", 256'(head(0)), 256'(32'hD0));
`ifdef INBUF_OVERFLOW_CHECK_EN
    check("vc0_overflow_err", 256'(overflow_err), 256'(4'b1000));
`endif
    for (int i = 0; i < 4; i++) begin
      expect_pop(0, 32'hD0 + 32'(i));
      step(1'b0, 0, '0, 4'b1000);
    end
    check("vc0_drained", 256'(is_new_flit), 256'(4'b0000));

    // VC 2: full, push X with same-cycle pop
    for (int i = 0; i < 4; i++) step(1'b1, 2, 32'hE0 + 32'(i), '0);
    check("vc2_full", 256'(full_out), 256'(4'b0010));
    expect_pop(2, 32'hE0); step(1'b1, 2, 32'h5A, 4'b0010);
    check("vc2_still_full", 256'(full_out), 256'(4'b0010));
    check("vc2_head_E1", 256'(head(2)), 256'(32'hE1));
`ifdef INBUF_OVERFLOW_CHECK_EN
    check("vc2_no_overflow", 256'(overflow_err), 256'(4'b1000));
`endif
    expect_pop(2, 32'hE1); step(1'b0, 0, '0, 4'b0010);
    expect_pop(2, 32'hE2); step(1'b0, 0, '0, 4'b0010);
    expect_pop(2, 32'hE3); step(1'b0, 0, '0, 4'b0010);
    expect_pop(2, 32'h5A); step(1'b0, 0, '0, 4'b0010);
    check("vc2_drained", 256'(is_new_flit), 256'(4'b0000));

    // Grants on all-empty VCs: no credits, pointers unmoved
    step(1'b0, 0, '0, 4'b1111);
    step(1'b0, 0, '0, 4'b1111);
    check("empty_grant_no_credit", 256'(credit_out), 256'(4'b0000));
    step(1'b1, 3, 32'hF1, '0);
    check("vc3_head_F1", 256'(head(3)), 256'(32'hF1));
    expect_pop(3, 32'hF1); step(1'b0, 0, '0, 4'b0001);

    // Interleaved VC 0 / VC 3 traffic with reset on cycle 6
    step(1'b1, 0, 32'h60, '0);                           // c1
    step(1'b1, 3, 32'h70, '0);                           // c2
    expect_pop(0, 32'h60); step(1'b1, 0, 32'h61, 4'b1000); // c3
    check("il_vc0_head_61", 256'(head(0)), 256'(32'h61));
    expect_pop(0, 32'h61); expect_pop(3, 32'h70);
    step(1'b1, 3, 32'h71, 4'b1001);                      // c4: two credits together
    step(1'b1, 0, 32'h62, '0);                           // c5
    check("il_pre_reset_nonempty", 256'(is_new_flit), 256'(4'b1001));
    reset = 1'b1;
    step(1'b1, 3, 32'h72, '0);                           // c6: reset
    reset = 1'b0;
    check("il_reset_is_new_flit", 256'(is_new_flit), 256'(4'b0000));
    check("il_reset_flit_out", 256'(flit_out), 256'(0));
    check("il_reset_full_out", 256'(full_out), 256'(4'b0000));
    check("il_reset_credit", 256'(credit_out), 256'(4'b0000));
`ifdef INBUF_OVERFLOW_CHECK_EN
    check("il_reset_overflow", 256'(overflow_err), 256'(4'b0000));
`endif
    step(1'b1, 0, 32'h63, '0);                           // c7
    step(1'b1, 3, 32'h73, '0);                           // c8
    check("il_post_reset_heads", 256'({head(0), head(3)}), 256'({32'h63, 32'h73}));
    expect_pop(0, 32'h63); expect_pop(3, 32'h73);
    step(1'b0, 0, '0, 4'b1001);                          // c9
    step(1'b0, 0, '0, '0);                               // c10
    check("il_final_empty", 256'(is_new_flit), 256'(4'b0000));

    repeat (3) step(1'b0, 0, '0, '0);
    check("pop_queue_drained", 256'(pop_q.size()), 256'(0));
    check("credit_queue_drained", 256'(cred_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_vc_buffer.md
INPUT_VC_BUFFER -- requirements
Module: input_vc_buffer

Interface
REQ-001 Parameter VC_NUM, default 4: number of virtual channels per input port; matches VC_NUM of the downstream priority stage.
REQ-002 Parameter DEPTH, default 4: flits per VC FIFO; power of two, at least 2.
REQ-003 Parameter VC_ID_W, default 2: width of the VC select field; 2**VC_ID_W >= VC_NUM.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flit_valid_in  input  1  a flit is presented this cycle.
REQ-007 flit_vc_in  input  VC_ID_W  target VC of the presented flit.
REQ-008 flit_in  input  `FLIT_SIZE  flit payload.
REQ-009 grant_in  input  VC_NUM  per-VC dequeue strobe, driven from the priority stage credit_for_input of that VC.
REQ-010 flit_out  output  `FLIT_SIZE*VC_NUM  head flit of VC v in slice v, VC 0 most significant.
REQ-011 is_new_flit  output  VC_NUM  bit v high when VC v FIFO is non-empty.
REQ-012 credit_out  output  VC_NUM  one-cycle credit pulse per dequeued flit, returned to the upstream router.
REQ-013 full_out  output  VC_NUM  bit v high when VC v holds DEPTH flits.

Function
REQ-014 Each VC SHALL be an independent circular FIFO with read pointer, write pointer (log2(DEPTH) bits, natural wrap) and occupancy count (log2(DEPTH)+1 bits).
REQ-015 Push: flit_valid_in=1 with flit_vc_in=v writes flit_in at the v write pointer on the clock edge; occupancy +1.
REQ-016 flit_vc_in >= VC_NUM SHALL discard the flit with no state change.
REQ-017 Pop: grant_in[v]=1 while VC v is non-empty advances the v read pointer on the clock edge; occupancy -1.
REQ-018 grant_in[v]=1 while VC v is empty SHALL be ignored and SHALL NOT produce a credit.
REQ-019 Same-cycle push and pop on one VC SHALL leave occupancy unchanged, including when the VC is full; this push is accepted.
REQ-020 Push to a full VC without a same-cycle pop SHALL be dropped; FIFO contents and pointers are unchanged.
REQ-021 flit_out slice v SHALL combinationally show the entry at the v read pointer when non-empty, and all zeros when empty.
REQ-022 is_new_flit and full_out SHALL be derived combinationally from registered occupancy, so a pushed flit becomes visible the cycle after the push edge (latency 1).
REQ-023 credit_out[v] SHALL be a registered pulse asserted exactly one cycle after each accepted pop edge, for one cycle per popped flit.
REQ-024 Pops on different VCs in the same cycle SHALL each produce their own credit pulse.

Reset
REQ-025 With reset high at a clock edge, all pointers, occupancies and credit_out SHALL clear to zero; is_new_flit=0, full_out=0 and flit_out=0 follow.
REQ-026 Flits presented or granted in a reset cycle SHALL be discarded; reset mid-operation loses buffered flits and emits no credits for them.
REQ-027 FIFO storage SHALL NOT require reset, and stale storage SHALL NOT be visible on flit_out.

Configuration
REQ-028 Macro INBUF_OVERFLOW_CHECK_EN defined: output overflow_err (VC_NUM bits) SHALL exist.
REQ-029 With the macro, bit v sets on any push dropped per REQ-020, stays set until reset, and is cleared by reset.
REQ-030 Macro undefined: overflow_err port and logic SHALL be absent, and drops SHALL be silent.

Verification
REQ-031 After reset: push A, B, C to VC 1 on consecutive cycles, then hold grant_in=4'b0100 for 3 cycles -> flit_out slice 1 shows A, B, C in order; credit_out[1] pulses 3 times, each one cycle after its pop edge; is_new_flit[1] falls after the third pop.
REQ-032 Push 4 flits to VC 0 (DEPTH=4) -> full_out[0]=1; a 5th push alone is dropped, with overflow_err[0]=1 when the macro is defined; the head is still the first flit.
REQ-033 VC 2 full, push X with grant_in[2]=1 in the same cycle -> count stays 4, X is the tail, and one credit_out[2] pulse.
REQ-034 grant_in=4'b1111 with all VCs empty -> no credit_out pulses, pointers unchanged.
REQ-035 Interleave pushes to VC 0 and VC 3 for 10 cycles with wrap-around -> per-VC order preserved; reset asserted on cycle 6 clears all outputs the next cycle and yields no credits for lost flits.
